ps2_key_tracker: RTL and testbench

//  Generalised PS/2 key tracker between PS2_Interface and processor/game logic.

---
 rtl/ps2_key_tracker.sv | 151 +++++++++++++++
 tb/tb_ps2_key_tracker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scancode decoder with held-key tracking, press/release pulses and an event FIFO.
// Optional PS2_TYPEMATIC_EN: repeated makes of a held key are reported as repeat events.
module ps2_key_tracker #(
    parameter int unsigned             NUM_KEYS   = 4,
    parameter logic [8*NUM_KEYS-1:0]   KEY_CODES  = {8'h1D, 8'h1C, 8'h5A, 8'h29},
    parameter int unsigned             FIFO_DEPTH = 8
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                ps2_key_pressed,
    input  logic [7:0]          ps2_key_data,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                ev_valid,
    output logic [7:0]          ev_data,
    input  logic                ev_ready,
    output logic                ev_overflow,
    input  logic                clr_overflow
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BRK     = 2'd1;
    localparam logic [1:0] S_EXT     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    logic [1:0]          state, state_nxt;
    logic                hit;
    logic [KW-1:0]       hit_sel;
    logic                do_make, do_break, do_bat;
    logic [NUM_KEYS-1:0] held_nxt, press_nxt, rel_nxt;
    logic                push, push_ok, pop, full;
    logic [7:0]          push_data;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;

    // Lowest matching index wins when KEY_CODES contains duplicates.
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (!hit && KEY_CODES[8*i +: 8] == ps2_key_data) begin
                hit     = 1'b1;
                hit_sel = KW'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        do_make   = 1'b0;
        do_break  = 1'b0;
        do_bat    = 1'b0;
        if (ps2_key_pressed) begin
            case (state)
                S_IDLE: begin
                    case (ps2_key_data)
                        8'hF0:                                    state_nxt = S_BRK;
                        8'hE0:                                    state_nxt = S_EXT;
                        8'hE1, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_nxt = S_IDLE;
                        8'hAA:                                    do_bat    = 1'b1;
                        default:                                  do_make   = 1'b1;
                    endcase
                end
                S_BRK: begin
                    do_break  = 1'b1;
                    state_nxt = S_IDLE;
                end
                S_EXT:   state_nxt = (ps2_key_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        held_nxt  = key_held;
        press_nxt = '0;
        rel_nxt   = '0;
        push      = 1'b0;
        push_data = '0;
        if (do_bat) begin
            held_nxt = '0;
        end else if (do_make && hit) begin
            if (!key_held[hit_sel]) begin
                held_nxt[hit_sel]  = 1'b1;
                press_nxt[hit_sel] = 1'b1;
                push               = 1'b1;
                push_data          = {2'b00, 6'(hit_sel)};
            end
`ifdef PS2_TYPEMATIC_EN
            else begin
                press_nxt[hit_sel] = 1'b1;
                push               = 1'b1;
                push_data          = {2'b01, 6'(hit_sel)};
            end
`endif
        end else if (do_break && hit && key_held[hit_sel]) begin
            held_nxt[hit_sel] = 1'b0;
            rel_nxt[hit_sel]  = 1'b1;
            push              = 1'b1;
            push_data         = {2'b10, 6'(hit_sel)};
        end
    end

    assign ev_valid = (count != '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign pop      = ev_valid && ev_ready;
    assign push_ok  = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
            ev_overflow <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ev_data     <= '0;
        end else begin
            state       <= state_nxt;
            key_held    <= held_nxt;
            key_press   <= press_nxt;
            key_release <= rel_nxt;
            if (push && !push_ok)  ev_overflow <= 1'b1;
            else if (clr_overflow) ev_overflow <= 1'b0;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // ev_data is a registered copy of the head so it can keep its last value once empty.
            if (pop) begin
                if (count > (AW+1)'(1)) ev_data <= mem[rd_ptr + AW'(1)];
                else if (push_ok)       ev_data <= push_data;
            end else if (!ev_valid && push_ok) begin
                ev_data <= push_data;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: a prefix-flag reference model predicts events,
// a negedge monitor compares held/pulse/overflow outputs and pops events on handshake.
module tb_ps2_key_tracker;
    localparam int unsigned         NUM_KEYS   = 4;
    localparam logic [8*NUM_KEYS-1:0] KEY_CODES = {8'h1D, 8'h1C, 8'h5A, 8'h29};
    localparam int unsigned         FIFO_DEPTH = 8;

    logic                clock, resetn;
    logic                ps2_key_pressed;
    logic [7:0]          ps2_key_data;
    logic [NUM_KEYS-1:0] key_held, key_press, key_release;
    logic                ev_valid, ev_ready, ev_overflow, clr_overflow;
    logic [7:0]          ev_data;

    ps2_key_tracker #(
        .NUM_KEYS   (NUM_KEYS),
        .KEY_CODES  (KEY_CODES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_key_data    (ps2_key_data),
        .key_held        (key_held),
        .key_press       (key_press),
        .key_release     (key_release),
        .ev_valid        (ev_valid),
        .ev_data         (ev_data),
        .ev_ready        (ev_ready),
        .ev_overflow     (ev_overflow),
        .clr_overflow    (clr_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    bit [NUM_KEYS-1:0] m_held, m_press, m_rel;
    bit                m_ovf;
    int                m_occ;
    bit                m_brk, m_ext, m_extbrk;
    logic [7:0]        sb_q[$];
    logic [7:0]        last_pop;
    bit                has_ev;
    logic [7:0]        ev, b;
    int                k;

    function automatic int find(input logic [7:0] code);
        for (int i = 0; i < NUM_KEYS; i++)
            if (KEY_CODES[8*i +: 8] == code) return i;
        return -1;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_held = '0; m_press = '0; m_rel = '0; m_ovf = 1'b0; m_occ = 0;
            m_brk = 1'b0; m_ext = 1'b0; m_extbrk = 1'b0;
            sb_q.delete();
            last_pop = '0;
        end else begin
            m_press = '0;
            m_rel   = '0;
            has_ev  = 1'b0;
            if (m_occ > 0 && ev_ready) m_occ--;
            if (ps2_key_pressed) begin
                b = ps2_key_data;
                if (m_extbrk) begin
                    m_extbrk = 1'b0;
                end else if (m_ext) begin
                    m_ext    = 1'b0;
                    m_extbrk = (b == 8'hF0);
                end else if (m_brk) begin
                    m_brk = 1'b0;
                    k = find(b);
                    if (k >= 0 && m_held[k]) begin
                        m_held[k] = 1'b0;
                        m_rel[k]  = 1'b1;
                        has_ev    = 1'b1;
                        ev        = {2'b10, 6'(k)};
                    end
                end else if (b == 8'hF0) begin
                    m_brk = 1'b1;
                end else if (b == 8'hE0) begin
                    m_ext = 1'b1;
                end else if (b == 8'hAA) begin
                    m_held = '0;
                end else if (!(b inside {8'hE1, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
                    k = find(b);
                    if (k >= 0) begin
                        if (!m_held[k]) begin
                            m_held[k]  = 1'b1;
                            m_press[k] = 1'b1;
                            has_ev     = 1'b1;
                            ev         = {2'b00, 6'(k)};
                        end else begin
`ifdef PS2_TYPEMATIC_EN
                            m_press[k] = 1'b1;
                            has_ev     = 1'b1;
                            ev         = {2'b01, 6'(k)};
`endif
                        end
                    end
                end
            end
            if (has_ev && m_occ >= FIFO_DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                if (has_ev) begin
                    m_occ++;
                    sb_q.push_back(ev);
                end
                if (clr_overflow) m_ovf = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        check("key_held", 32'(key_held), 32'(m_held));
        check("key_press", 32'(key_press), 32'(m_press));
        check("key_release", 32'(key_release), 32'(m_rel));
        check("ev_overflow", 32'(ev_overflow), 32'(m_ovf));
        check("ev_valid", 32'(ev_valid), 32'(sb_q.size() != 0));
        if (sb_q.size() == 0) begin
            check("ev_data_hold", 32'(ev_data), 32'(last_pop));
        end else if (ev_valid && ev_ready) begin
            last_pop = sb_q.pop_front();
            check("ev_data_pop", 32'(ev_data), 32'(last_pop));
        end else begin
            check("ev_data_head", 32'(ev_data), 32'(sb_q[0]));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] code);
        ps2_key_data    = code;
        ps2_key_pressed = 1'b1;
        tick();
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'($urandom);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    logic [7:0] pool [12] = '{8'h29, 8'h5A, 8'h1C, 8'h1D, 8'hF0, 8'hE0,
                              8'hE1, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h33};

    initial begin
        resetn = 1'b0; ps2_key_pressed = 1'b0; ps2_key_data = '0;
        ev_ready = 1'b0; clr_overflow = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        ev_ready = 1'b1;
        send(8'h29); tick();
        send(8'hF0); send(8'h29); send(8'hF0); send(8'h29);
        repeat (3) send(8'h5A);
        send(8'hF0); send(8'h5A);
        send(8'hE0); send(8'h29); send(8'hE0); send(8'hF0); send(8'h29);
        send(8'h29); send(8'hF0); send(8'h29);

        // Fill past capacity with the consumer stalled, then push while popping at full.
        ev_ready = 1'b0;
        repeat (5) begin send(8'h1C); send(8'hF0); send(8'h1C); end
        ev_ready = 1'b1;
        send(8'h1C);
        ev_ready = 1'b0;
        tick();
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        ev_ready = 1'b1;
        repeat (12) tick();

        send(8'h29); send(8'h1C); send(8'hAA);
        send(8'h29); send(8'hF0);
        resetn = 1'b0; tick(); tick(); resetn = 1'b1; tick();
        send(8'h29); send(8'hF0); send(8'h29);

        for (int n = 0; n < 2500; n++) begin
            ev_ready        = ((n / 200) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            clr_overflow    = ($urandom_range(0, 40) == 0);
            ps2_key_pressed = ($urandom_range(0, 1) == 1);
            ps2_key_data    = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
            if ($urandom_range(0, 700) == 0) resetn = 1'b0;
            tick();
            resetn = 1'b1;
        end

        ps2_key_pressed = 1'b0; clr_overflow = 1'b0; ev_ready = 1'b1;
        repeat (FIFO_DEPTH + 4) tick();
        check("drained", 32'(sb_q.size()), 32'd0);
        check("final_valid", 32'(ev_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
